// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared fetch-controller types and constants.
//  Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned c_fifo_depth = 2;
    localparam logic [63:0] c_pc_incr    = 64'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Small {pc, instr} FIFO between the fetch engine and decode.
//  Revision : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [63:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        pop,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output logic [63:0] head_pc,
    output logic [31:0] head_instr
);

    localparam int PTR_W = $clog2(c_fifo_depth);
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      r_pc_mem    [c_fifo_depth];
    logic [31:0]      r_instr_mem [c_fifo_depth];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full       = (r_count == CNT_W'(c_fifo_depth));
    assign empty      = (r_count == '0);
    assign w_do_pop   = pop && !empty;
    assign w_do_push  = push && (!full || w_do_pop);
    assign head_pc    = r_pc_mem[r_rd_ptr];
    assign head_instr = r_instr_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < c_fifo_depth; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_pc_mem[r_wr_ptr]    <= push_pc;
                r_instr_mem[r_wr_ptr] <= push_instr;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl
//  Brief    : Instruction fetch controller with redirect, halt and 2-deep queue.
//  Revision : 1.0
// ============================================================================
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IM_AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             br_taken,
    input  logic [63:0]      br_target,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [63:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic             misalign
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [63:0] r_pc;
    logic        r_inflight;
    logic [63:0] r_inflight_pc;
    logic        r_misalign;

    logic        w_full;
    logic        w_empty;
    logic [63:0] w_head_pc;
    logic [31:0] w_head_instr;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_occ;
    logic [2:0]  w_used;
    logic        w_issue;

    assign w_occ  = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    assign w_pop  = !w_empty && if_ready;
    // A redirect discards the response arriving this cycle.
    assign w_push = r_inflight && !br_taken;

    // A dequeue in the same cycle frees a slot, allowing one fetch per cycle.
    assign w_used = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = halt_req ? ST_HALTED : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (halt_req) begin
                    w_state_next = ST_HALTED;
                end else if (!br_taken && (w_used < 3'(c_fifo_depth))) begin
                    w_issue = 1'b1;
                end
            end
            ST_HALTED: begin
                if (start && !halt_req) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            r_misalign <= br_taken && (br_target[1:0] != 2'b00);
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
            if (br_taken) begin
                r_pc <= {br_target[63:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + c_pc_incr;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_pc    (r_inflight_pc),
        .push_instr (im_rdata),
        .pop        (w_pop),
        .flush      (br_taken),
        .full       (w_full),
        .empty      (w_empty),
        .head_pc    (w_head_pc),
        .head_instr (w_head_instr)
    );

    assign im_req   = w_issue;
    assign im_addr  = r_pc[IM_AW+1:2];
    assign if_valid = !w_empty;
    assign if_pc    = w_empty ? 64'd0 : w_head_pc;
    assign if_instr = w_empty ? 32'd0 : w_head_instr;
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 64'h0, byte address loaded into the PC at reset.
REQ-002 Parameter: IM_AW, 5, instruction-memory word-index width (32 words).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  level; leaves IDLE or HALTED and begins fetching.
REQ-006 Port: halt_req  in  1  level; stops issue and enters HALTED.
REQ-007 Port: br_taken  in  1  one-cycle pulse; redirect the PC.
REQ-008 Port: br_target  in  64  redirect byte address.
REQ-009 Port: im_req  out  1  read strobe to instruction memory.
REQ-010 Port: im_addr  out  IM_AW  word index, equal to pc[IM_AW+1:2].
REQ-011 Port: im_rdata  in  32  read data; valid exactly one cycle after im_req.
REQ-012 Port: if_valid  out  1  queue head holds an instruction.
REQ-013 Port: if_ready  in  1  decode accepts the head.
REQ-014 Port: if_pc  out  64  byte PC of the head instruction.
REQ-015 Port: if_instr  out  32  head instruction word.
REQ-016 Port: misalign  out  1  one-cycle pulse; br_target[1:0] was nonzero.

Function
REQ-017 FSM states SHALL be IDLE, FETCH and HALTED; IDLE->FETCH on start; FETCH->HALTED on halt_req; HALTED->FETCH on start with halt_req low.
REQ-018 In FETCH the block SHALL assert im_req only when queue occupancy plus in-flight count is below 2, and no redirect occurs that cycle.
REQ-019 Each issued im_req SHALL advance pc by 4, wrapping modulo 2^64.
REQ-020 The response SHALL be written with its pc into a 2-entry FIFO one cycle after im_req; the in-flight count is 0 or 1.
REQ-021 if_valid SHALL equal FIFO non-empty; a beat transfers when if_valid and if_ready are both high.
REQ-022 Enqueue and dequeue in the same cycle SHALL keep occupancy unchanged; with an empty FIFO, the response SHALL appear at the head on the next cycle (no bypass).
REQ-023 Steady state with if_ready held high SHALL sustain one instruction per cycle after a 2-cycle start latency (start edge to first if_valid).
REQ-024 br_taken SHALL flush the FIFO, discard any in-flight response, and load pc with {br_target[63:2],2'b00}; the first post-redirect im_req SHALL occur on the following cycle.
REQ-025 br_taken with br_target[1:0]!=0 SHALL additionally pulse misalign for one cycle.
REQ-026 Priority SHALL be reset > halt_req > br_taken > normal issue/dequeue; a handshake coinciding with br_taken counts as consumed.
REQ-027 In HALTED or IDLE, im_req SHALL be 0; the FIFO and the in-flight response SHALL drain normally to decode.
REQ-028 br_taken in HALTED or IDLE SHALL update pc and flush the FIFO without a state change.
REQ-029 halt_req and start both high SHALL leave or keep the FSM in HALTED.

Reset
REQ-030 On reset the block SHALL set: state IDLE, pc RESET_PC, FIFO empty, in-flight 0, im_req 0, if_valid 0, misalign 0; if_pc and if_instr SHALL be 0.
REQ-031 Reset mid-operation SHALL discard any in-flight response; nothing SHALL be enqueued on the cycle after reset.

Structure
REQ-032 FSM state encoding, the 2-entry depth constant and the PC increment constant (4) SHALL reside in a shared package, fetch_pkg.
REQ-033 The 2-entry {pc,instr} FIFO SHALL be a sub-module, fetch_fifo, with push, pop, flush, full and empty.

Verification
REQ-034 Reset, start, if_ready=1, memory words 0..3 = A,B,C,D -> if_instr A,B,C,D with if_pc 0,4,8,C on consecutive cycles.
REQ-035 Hold if_ready=0 after start -> exactly two entries queued, im_req deasserted, pc=8; release -> A,B then C, with no loss or duplicate.
REQ-036 br_taken with target 0x40 while an in-flight response and one queued entry exist -> both dropped, next if_pc=0x40, word 16.
REQ-037 br_taken with target 0x42 -> misalign pulses for one cycle, fetch resumes at 0x40.
REQ-038 halt_req in FETCH -> im_req=0 on the next cycle, queued entries still delivered; start -> fetch resumes at the saved pc.
REQ-039 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, start -> if_pc FFFC then 0x0 (wrap).
